// File: rtl/count_tick_pkg.sv
// -----------------------------------------------------------------------------
// count_tick_pkg
//   Shared definitions for the enable-tick generator: the FSM state encoding
//   and the default widths of the divide and burst-length fields.
// -----------------------------------------------------------------------------
package count_tick_pkg;

    localparam int DEF_DIV_W   = 8;
    localparam int DEF_BURST_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : count_tick_pkg

// File: rtl/count_tick_gen_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//   Free-running prescale counter that restarts whenever it reaches the
//   divide value. It flags the cycle where presc == div.
// Ports
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-high reset (presc -> 0)
//   clear  in   force presc to 0 at the next edge (has priority over run)
//   run    in   advance the prescaler this edge
//   div    in   divide value; period is div+1 edges
//   tick   out  combinational, high when presc == div
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] presc_q;
    logic [DIV_W-1:0] presc_d;

    assign tick = (presc_q == div);

    // presc is restarted on every tick, so it never exceeds div and
    // never wraps.
    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (run) begin
            if (tick) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule : tick_prescaler

// File: rtl/count_tick_gen.sv
// -----------------------------------------------------------------------------
// count_tick_gen
//   Programmable enable-tick generator for a counter stage. Divides the clock
//   by cfg_div+1 and emits one-cycle enable pulses, either continuously
//   (cfg_burst == 0) or as a burst of cfg_burst pulses followed by a done
//   pulse. Configuration is loaded by a valid/ready handshake in IDLE.
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   cfg_valid  in   configuration offer
//   cfg_ready  out  high in IDLE; config taken when cfg_valid & cfg_ready
//   cfg_div    in   divide value (tick period = cfg_div+1 cycles)
//   cfg_burst  in   burst length, 0 = continuous
//   start      in   start generation (only honoured in IDLE)
//   stop       in   abort generation (wins over start, ignored in DONE)
//   enable     out  registered one-cycle tick
//   busy       out  registered, high while in RUN or DONE
//   done       out  registered one-cycle pulse after the last burst tick
// -----------------------------------------------------------------------------
module count_tick_gen
    import count_tick_pkg::*;
#(
    parameter int DIV_W   = DEF_DIV_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               enable,
    output logic               busy,
    output logic               done
);

    state_t               state_q,     state_d;
    logic [DIV_W-1:0]     div_q,       div_d;
    logic [BURST_W-1:0]   burst_q,     burst_d;
    logic [BURST_W-1:0]   remaining_q, remaining_d;
    logic                 enable_q,    enable_d;
    logic                 busy_q,      busy_d;
    logic                 done_q,      done_d;

    logic                 cfg_hs;
    logic                 start_ok;
    logic                 tick;
    logic                 presc_clear;
    logic                 presc_run;
    logic                 last_tick;

    assign cfg_ready = (state_q == IDLE);
    assign cfg_hs    = cfg_valid & cfg_ready;
    assign start_ok  = start & ~stop;

    // The prescaler only counts in RUN; it is held at zero elsewhere and
    // cleared on stop so a later start always begins a fresh period.
    assign presc_run   = (state_q == RUN);
    assign presc_clear = (state_q != RUN) | stop;

    tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (presc_clear),
        .run   (presc_run),
        .div   (div_q),
        .tick  (tick)
    );

    // Final tick of a finite burst: remaining never drops below 1.
    assign last_tick = tick & (burst_q != '0) & (remaining_q == BURST_W'(1));

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            burst_q     <= '0;
            remaining_q <= '0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            burst_q     <= burst_d;
            remaining_q <= remaining_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_ok) state_d = RUN;
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (last_tick) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // --------------------------------------------------- outputs / datapath
    always_comb begin
        div_d       = div_q;
        burst_d     = burst_q;
        remaining_d = remaining_q;
        enable_d    = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_hs) begin
                    div_d   = cfg_div;
                    burst_d = cfg_burst;
                end
                // A handshake in the same cycle as start supplies the burst.
                if (start_ok) begin
                    remaining_d = cfg_hs ? cfg_burst : burst_q;
                end
            end
            RUN: begin
                if (!stop && tick) begin
                    enable_d = 1'b1;
                    if (burst_q != '0) begin
                        remaining_d = remaining_q - BURST_W'(1);
                    end
                end
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign enable = enable_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule : count_tick_gen

// File: tb/tb_count_tick_gen.sv
module tb_count_tick_gen;

    logic       clock;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_div;
    logic [3:0] cfg_burst;
    logic       start;
    logic       stop;
    logic       enable;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string    tag;
        logic [3:0] exp;   // {enable, busy, done, cfg_ready}
    } item_t;

    item_t sb_q[$];

    logic [3:0] cnt;   // 4-bit counter stage driven by enable

    count_tick_gen dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_burst (cfg_burst),
        .start     (start),
        .stop      (stop),
        .enable    (enable),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset) cnt <= 4'd0;
        else if (enable) cnt <= cnt + 4'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input string tag, input logic en, input logic bs,
                        input logic dn, input logic rdy);
        item_t it;
        it.tag = tag;
        it.exp = {en, bs, dn, rdy};
        sb_q.push_back(it);
    endtask

    task automatic check_now();
        item_t it;
        logic [3:0] obs;
        obs = {enable, busy, done, cfg_ready};
        tests++;
        if (sb_q.size() == 0) begin
            fails++;
            $error("FAIL sb_underflow: observed empty queue, expected entry");
        end else begin
            it = sb_q.pop_front();
            assert (obs === it.exp) else begin
                fails++;
                $error("FAIL %s: observed en/busy/done/rdy=%b expected %b",
                       it.tag, obs, it.exp);
            end
            $display("[TB] %s en/busy/done/rdy=%b", it.tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        check_now();
    endtask

    task automatic idle_inputs();
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cfg_valid = 1'b0; cfg_div = 8'd0; cfg_burst = 4'd0;
        start = 1'b0; stop = 1'b0;
        @(posedge clock); #1;
        push("reset", 0, 0, 0, 1); check_now();
        reset = 1'b0;

        // 1: div=2 continuous
        cfg_valid = 1; cfg_div = 8'd2; cfg_burst = 4'd0; start = 1;
        push("t1_start", 0, 1, 0, 0); tick();
        idle_inputs();
        for (int k = 1; k <= 13; k++) begin
            push($sformatf("t1_k%0d", k), (k % 3 == 0), 1, 0, 0); tick();
        end
        tests++;
        assert (cnt === 4'd4) else begin
            fails++;
            $error("FAIL t1_counter: observed %0d expected 4", cnt);
        end
        stop = 1;
        push("t1_stop", 0, 0, 0, 1); tick();
        idle_inputs();

        // 2: div=0 burst=5
        cfg_valid = 1; cfg_div = 8'd0; cfg_burst = 4'd5; start = 1;
        push("t2_start", 0, 1, 0, 0); tick();
        idle_inputs();
        for (int k = 1; k <= 5; k++) begin
            push($sformatf("t2_k%0d", k), 1, 1, 0, 0); tick();
        end
        push("t2_done", 0, 0, 1, 1); tick();
        push("t2_after", 0, 0, 0, 1); tick();

        // 3: div=3 continuous, stop on would-be tick
        cfg_valid = 1; cfg_div = 8'd3; cfg_burst = 4'd0; start = 1;
        push("t3_start", 0, 1, 0, 0); tick();
        idle_inputs();
        for (int k = 1; k <= 7; k++) begin
            push($sformatf("t3_k%0d", k), (k == 4), 1, 0, 0); tick();
        end
        stop = 1;
        push("t3_stop", 0, 0, 0, 1); tick();
        idle_inputs();
        push("t3_idle", 0, 0, 0, 1); tick();

        // 4: handshake+start with div=1, cfg held during RUN, start in RUN
        cfg_valid = 1; cfg_div = 8'd1; cfg_burst = 4'd0; start = 1;
        push("t4_start", 0, 1, 0, 0); tick();
        start = 0;
        cfg_valid = 1; cfg_div = 8'd0; cfg_burst = 4'd2;
        for (int k = 1; k <= 6; k++) begin
            start = (k == 3);
            push($sformatf("t4_k%0d", k), (k % 2 == 0), 1, 0, 0); tick();
        end
        start = 0; stop = 1;
        push("t4_stop", 0, 0, 0, 1); tick();
        stop = 0;
        push("t4_load", 0, 0, 0, 1); tick();
        cfg_valid = 0; start = 1;
        push("t4_start2", 0, 1, 0, 0); tick();
        start = 0;
        push("t4_b1", 1, 1, 0, 0); tick();
        push("t4_b2", 1, 1, 0, 0); tick();
        push("t4_done", 0, 0, 1, 1); tick();
        push("t4_after", 0, 0, 0, 1); tick();

        // 6a: start and stop together in IDLE
        start = 1; stop = 1;
        push("t6_startstop", 0, 0, 0, 1); tick();
        idle_inputs();
        push("t6_idle", 0, 0, 0, 1); tick();

        // 5: async reset mid-burst
        cfg_valid = 1; cfg_div = 8'd1; cfg_burst = 4'd8; start = 1;
        push("t5_start", 0, 1, 0, 0); tick();
        idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            push($sformatf("t5_k%0d", k), (k % 2 == 0), 1, 0, 0); tick();
        end
        #2 reset = 1'b1;
        #1;
        push("t5_async", 0, 0, 0, 1); check_now();
        #1 reset = 1'b0;
        push("t5_post", 0, 0, 0, 1); tick();
        // cleared div/burst: every-cycle ticks that never end in DONE
        start = 1;
        push("t5_start0", 0, 1, 0, 0); tick();
        start = 0;
        for (int k = 1; k <= 10; k++) begin
            push($sformatf("t5_c%0d", k), 1, 1, 0, 0); tick();
        end
        stop = 1;
        push("t5_stop", 0, 0, 0, 1); tick();
        idle_inputs();

        tests++;
        assert (sb_q.size() == 0) else begin
            fails++;
            $error("FAIL sb_leftover: observed %0d expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_count_tick_gen
